uart_echo_fifo: RTL
===================

// Module: uart_echo_fifo
// PURPOSE
//  Parametrised RS-232 echo channel: 8N1-style receiver, FIFO buffer and transmitter in one block.
//  Echoes every valid received frame, in order, on the TX line; iTXEN pauses echo without losing data.
//  Flags framing errors and overruns. Successor to the unbuffered rx->tx loopback top level.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency (Hz)
//  BAUD        115_200     line rate; DIV = CLK_HZ/BAUD (integer divide), DIV >= 4 required
//  DATA_BITS   8           payload bits per frame, 5..9
//  FIFO_DEPTH  16          entries, power of two, >= 2
// PORTS
//  clk_s      in   1                       system clock, all logic on rising edge
//  rstn_s     in   1                       synchronous reset, active-low
//  iDATA      in   1                       serial RX line, asynchronous, idle high
//  iTXEN      in   1                       1 = TX may start a new frame; 0 = hold after current frame
//  oDATA      out  DATA_BITS               last valid received word
//  oDONE      out  1                       1-cycle pulse: valid frame received, oDATA updated
//  oFERR      out  1                       1-cycle pulse: stop bit sampled low
//  oOVERRUN   out  1                       sticky: word dropped because FIFO full; cleared only by reset
//  oFULL      out  1                       FIFO full
//  oEMPTY     out  1                       FIFO empty
//  oLEVEL     out  $clog2(FIFO_DEPTH)+1    FIFO occupancy
//  oTXDATA    out  1                       serial TX line, idle high
// BEHAVIOUR
//  Reset (rstn_s=0 at edge): oDATA=0, oDONE=0, oFERR=0, oOVERRUN=0, oFULL=0, oEMPTY=1, oLEVEL=0,
//   oTXDATA=1, RX/TX FSMs -> IDLE, FIFO pointers 0, sync flops = 1. Reset mid-frame aborts both
//   directions; oTXDATA is high the cycle after the reset edge.
//  RX sync: iDATA through 2 flops; all RX decisions use synced value.
//  RX FSM: IDLE -> START on synced 1->0. START: at DIV/2 cycles sample; 1 -> IDLE (glitch, no flag);
//   0 -> DATA. DATA: DATA_BITS samples, DIV cycles apart, LSB first. [PARITY] -> STOP after DIV.
//   STOP: sample 1 -> oDONE, oDATA<=word, push; sample 0 -> oFERR, no push, state WAIT until
//   synced line is 1, then IDLE. RX returns to IDLE at mid-stop, so back-to-back frames are accepted.
//  FIFO: pointers carry extra wrap bit; full = ptrs equal except MSB; empty = ptrs equal.
//   Push while full: word dropped, oOVERRUN<=1, contents unchanged. Push and pop same cycle: both
//   happen (push while full only if pop occurs same cycle). oLEVEL/oFULL/oEMPTY registered, valid
//   the cycle after the push/pop.
//  TX FSM: IDLE: if !oEMPTY && iTXEN -> pop head, load shifter, -> START (oTXDATA=0 from next cycle).
//   START DIV cycles low; DATA DATA_BITS x DIV cycles LSB first; [PARITY] DIV cycles; STOP DIV
//   cycles high -> IDLE. iTXEN sampled only in IDLE; deasserting it never truncates a frame.
//   Min gap between echoed frames: 1 cycle (IDLE) after stop.
//  Latency: oDONE to first TX start-bit cycle = 2 cycles when FIFO empty, TX idle, iTXEN=1.
//  Bit counters and divider: $clog2(DIV) bits, reload on every bit boundary; no drift accumulates.
// CONFIGURATION
//  PARITY_EN defined: one even-parity bit after data in both directions. RX parity mismatch ->
//   oPERR (extra out port, 1-cycle pulse coincident with stop sample), word dropped, no oDONE;
//   framing error takes priority (oFERR only). TX sends XOR of data bits.
//  PARITY_EN undefined: no parity state, no oPERR port; frame = start + DATA_BITS + stop.
// TESTING (CLK_HZ=50_000_000, BAUD=5_000_000 -> DIV=10, DATA_BITS=8, FIFO_DEPTH=16)
//  1 Send 0xA5, iTXEN=1 -> one oDONE pulse, oDATA=0xA5, oTXDATA frame 0,1,0,1,0,0,1,0,1,1 at 10 cyc/bit.
//  2 iTXEN=0, send 17 bytes 0x00..0x10 -> oFULL=1, oLEVEL=16 after 16th; 17th dropped, oOVERRUN=1;
//    then iTXEN=1 -> 0x00..0x0F echoed in order, oEMPTY=1 at end, oOVERRUN still 1.
//  3 Frame 0x3C with stop bit 0 -> oFERR pulse, no oDONE, oLEVEL unchanged; next good 0x55 accepted.
//  4 iDATA low for 3 cycles then high -> no oDONE/oFERR, RX back in IDLE, line stays idle.
//  5 PARITY_EN: send 0x07 with parity 0 -> oPERR pulse, no push; send 0x07 with parity 1 ->
//    echoed with parity bit 1 (11-bit frame).
//  6 rstn_s=0 during TX data bit 3 with oLEVEL=4 -> next cycle oTXDATA=1, oEMPTY=1, oLEVEL=0, all flags 0.

Source files
------------

// File: rtl/uart_echo_fifo.sv
// UART echo channel: 2-flop synchronised RX, FIFO buffer and TX sharing one clock domain.
// Optional even parity in both directions when the PARITY_EN macro is defined, which adds the oPERR port.
//
// RX FSM  state   | meaning
//         RX_IDLE | line idle, waiting for synced falling edge
//         RX_START| counting to mid start bit, rejects glitches
//         RX_DATA | sampling payload bits LSB first
//         RX_PAR  | sampling parity bit (PARITY_EN only)
//         RX_STOP | sampling stop bit, push or flag error
//         RX_WAIT | framing error seen, waiting for line high
// TX FSM  state   | meaning
//         TX_IDLE | line high, pops head when allowed
//         TX_START| start bit low
//         TX_DATA | payload bits LSB first
//         TX_PAR  | parity bit (PARITY_EN only)
//         TX_STOP | stop bit high
module uart_echo_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_s,
    input  logic                          rstn_s,
    input  logic                          iDATA,
    input  logic                          iTXEN,
    output logic [DATA_BITS-1:0]          oDATA,
    output logic                          oDONE,
    output logic                          oFERR,
`ifdef PARITY_EN
    output logic                          oPERR,
`endif
    output logic                          oOVERRUN,
    output logic                          oFULL,
    output logic                          oEMPTY,
    output logic [$clog2(FIFO_DEPTH):0]   oLEVEL,
    output logic                          oTXDATA
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef PARITY_EN
        RX_PAR,
`endif
        RX_STOP, RX_WAIT
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef PARITY_EN
        TX_PAR,
`endif
        TX_STOP
    } tx_state_t;

    logic                 sync1, sync2;
    rx_state_t            rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_word;
`ifdef PARITY_EN
    logic                 rx_par;
`endif

    always_ff @(posedge clk_s) begin
        if (!rstn_s) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_word  <= '0;
            oDATA    <= '0;
            oDONE    <= 1'b0;
            oFERR    <= 1'b0;
`ifdef PARITY_EN
            oPERR    <= 1'b0;
            rx_par   <= 1'b0;
`endif
        end else begin
            sync1 <= iDATA;
            sync2 <= sync1;
            oDONE <= 1'b0;
            oFERR <= 1'b0;
`ifdef PARITY_EN
            oPERR <= 1'b0;
`endif
            case (rx_state)
                RX_IDLE: begin
                    if (!sync2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= CNT_HALF;
                    end
                end
                RX_START: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else if (sync2) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= CNT_FULL;
                        rx_bit   <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_word <= {sync2, rx_word[DATA_BITS-1:1]};
                        rx_cnt  <= CNT_FULL;
                        if (rx_bit == LAST_BIT) begin
`ifdef PARITY_EN
                            rx_state <= RX_PAR;
`else
                            rx_state <= RX_STOP;
`endif
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
`ifdef PARITY_EN
                RX_PAR: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else begin
                        rx_par   <= sync2;
                        rx_cnt   <= CNT_FULL;
                        rx_state <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_cnt != '0) begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end else if (!sync2) begin
                        oFERR    <= 1'b1;
                        rx_state <= RX_WAIT;
`ifdef PARITY_EN
                    end else if (^{rx_word, rx_par}) begin
                        oPERR    <= 1'b1;
                        rx_state <= RX_IDLE;
`endif
                    end else begin
                        // Leaving at mid-stop lets a back-to-back start edge be caught.
                        oDONE    <= 1'b1;
                        oDATA    <= rx_word;
                        rx_state <= RX_IDLE;
                    end
                end
                RX_WAIT: begin
                    if (sync2) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // oDONE doubles as the push strobe, with oDATA as the write word.
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr, wr_next, rd_next;
    logic                 push_ok, pop;
    tx_state_t            tx_state;

    assign pop     = (tx_state == TX_IDLE) && !oEMPTY && iTXEN;
    assign push_ok = oDONE && (!oFULL || pop);
    assign wr_next = wr_ptr + {{AW{1'b0}}, push_ok};
    assign rd_next = rd_ptr + {{AW{1'b0}}, pop};

    always_ff @(posedge clk_s) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= oDATA;
    end

    always_ff @(posedge clk_s) begin
        if (!rstn_s) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            oLEVEL   <= '0;
            oFULL    <= 1'b0;
            oEMPTY   <= 1'b1;
            oOVERRUN <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            oLEVEL <= wr_next - rd_next;
            oFULL  <= (wr_next ^ rd_next) == {1'b1, {AW{1'b0}}};
            oEMPTY <= wr_next == rd_next;
            if (oDONE && !push_ok) oOVERRUN <= 1'b1;
        end
    end

    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
`ifdef PARITY_EN
    logic                 tx_par;
`endif

    always_ff @(posedge clk_s) begin
        if (!rstn_s) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            oTXDATA  <= 1'b1;
`ifdef PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    oTXDATA <= 1'b1;
                    if (pop) begin
                        tx_shift <= mem[rd_ptr[AW-1:0]];
`ifdef PARITY_EN
                        tx_par   <= ^mem[rd_ptr[AW-1:0]];
`endif
                        oTXDATA  <= 1'b0;
                        tx_cnt   <= CNT_FULL;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        oTXDATA  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                        tx_cnt   <= CNT_FULL;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        tx_cnt <= CNT_FULL;
                        if (tx_bit == LAST_BIT) begin
`ifdef PARITY_EN
                            oTXDATA  <= tx_par;
                            tx_state <= TX_PAR;
`else
                            oTXDATA  <= 1'b1;
                            tx_state <= TX_STOP;
`endif
                        end else begin
                            oTXDATA  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                end
`ifdef PARITY_EN
                TX_PAR: begin
                    if (tx_cnt != '0) begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end else begin
                        oTXDATA  <= 1'b1;
                        tx_cnt   <= CNT_FULL;
                        tx_state <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
                    else              tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule
